// File: rtl/loop_pred_update_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | loop_pred_update_queue: buffers up to COMMIT_WIDTH committed branch       |
// | records per cycle and drains them one per cycle to the loop predictor.   |
// | Option macro: LOOP_PRED_UPDQ_COND_FILTER_EN (queue conditional lanes only)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module loop_pred_update_queue #(
  parameter int COMMIT_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int PC_WIDTH     = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [COMMIT_WIDTH-1:0]          commit_valid_i,
  input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] commit_pc_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_is_cond_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_taken_i,
  output logic                             commit_ready_o,
  output logic                             update_valid_o,
  output logic [PC_WIDTH-1:0]              update_pc_o,
  output logic                             update_is_cond_o,
  output logic                             update_taken_o,
  output logic [$clog2(DEPTH):0]           count_o,
  output logic                             overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CW_C    = CNT_W'(COMMIT_WIDTH);

  logic [PC_WIDTH-1:0] pc_mem_q [DEPTH];
  logic [DEPTH-1:0]    cond_mem_q;
  logic [DEPTH-1:0]    taken_mem_q;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             primed_q, primed_d;

  logic [COMMIT_WIDTH-1:0] lane_en;
  logic [PTR_W-1:0]        slot [COMMIT_WIDTH];
  logic [CNT_W-1:0]        lane_n;
  logic [CNT_W-1:0]        enq_n;
  logic                    deq;

`ifdef LOOP_PRED_UPDQ_COND_FILTER_EN
  assign lane_en = commit_valid_i & commit_is_cond_i;
`else
  assign lane_en = commit_valid_i;
`endif

  // Ready looks only at the registered count; the same-cycle pop is ignored on purpose.
  assign commit_ready_o = (DEPTH_C - count_q) >= CW_C;
  assign deq            = (count_q != '0);

  always_comb begin
    lane_n = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot[k] = tail_q + lane_n[PTR_W-1:0];
      if (lane_en[k]) lane_n = lane_n + CNT_W'(1);
    end
  end

  always_comb begin
    enq_n      = commit_ready_o ? lane_n : '0;
    head_d     = head_q + PTR_W'(deq);
    tail_d     = tail_q + enq_n[PTR_W-1:0];
    count_d    = count_q + enq_n - CNT_W'(deq);
    overflow_d = overflow_q | (~commit_ready_o & (|lane_en));
    primed_d   = primed_q | (enq_n != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      primed_q   <= primed_d;
    end
  end

  // Entry storage carries no reset; lanes are compacted into consecutive slots.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (commit_ready_o && lane_en[k]) begin
        pc_mem_q[slot[k]]    <= commit_pc_i[k*PC_WIDTH +: PC_WIDTH];
        cond_mem_q[slot[k]]  <= commit_is_cond_i[k];
        taken_mem_q[slot[k]] <= commit_taken_i[k];
      end
    end
  end

  // Until the first write after reset the head slot holds no defined record, so show zeros.
  assign update_valid_o = deq;
  assign update_pc_o    = primed_q ? pc_mem_q[head_q] : '0;
  assign update_taken_o = primed_q & taken_mem_q[head_q];
`ifdef LOOP_PRED_UPDQ_COND_FILTER_EN
  assign update_is_cond_o = deq | (primed_q & cond_mem_q[head_q]);
`else
  assign update_is_cond_o = primed_q & cond_mem_q[head_q];
`endif
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
`default_nettype wire
